// File: rtl/drink_status_moore.sv
// Vending controller FSM: accumulates half-unit credit toward a 2.5 price and
// flags a one-cycle dispense with change due. Outputs come straight from flops.
module drink_status_moore (
  input  logic       clk,
  input  logic       reset,
  input  logic       half,
  input  logic       one,
  output logic       out,
  output logic [1:0] cout
);

  typedef enum logic [2:0] {
    C0 = 3'd0, C1 = 3'd1, C2 = 3'd2, C3 = 3'd3, C4 = 3'd4,
    D0 = 3'd5, D1 = 3'd6, D2 = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic       out_q, out_d;
  logic [1:0] cout_q, cout_d;
  logic [2:0] base, t;

  always_comb begin
    // Dispense states hand over with zero credit, so a new purchase can start at once.
    case (state_q)
      C1:      base = 3'd1;
      C2:      base = 3'd2;
      C3:      base = 3'd3;
      C4:      base = 3'd4;
      default: base = 3'd0;
    endcase
    t = base + {1'b0, one, half};
    case (t)
      3'd0:    state_d = C0;
      3'd1:    state_d = C1;
      3'd2:    state_d = C2;
      3'd3:    state_d = C3;
      3'd4:    state_d = C4;
      3'd5:    state_d = D0;
      3'd6:    state_d = D1;
      3'd7:    state_d = D2;
      default: state_d = C0;
    endcase
    out_d  = (state_d == D0) || (state_d == D1) || (state_d == D2);
    cout_d = 2'd0;
    if (state_d == D1) cout_d = 2'd1;
    if (state_d == D2) cout_d = 2'd2;
  end

  // Outputs are registered alongside the state so they always equal its decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= C0;
      out_q   <= 1'b0;
      cout_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
    end
  end

  assign out  = out_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_drink_status_moore.sv
// Randomized + directed check of drink_status_moore against a credit-counting model.
`timescale 1ns/1ps
module tb_drink_status_moore;
  logic       clk = 1'b0;
  logic       reset;
  logic       half, one;
  logic       out;
  logic [1:0] cout;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: plain credit total in half-units.
  int m_credit = 0;
  bit m_disp   = 1'b0;
  int m_chg    = 0;

  drink_status_moore dut (
    .clk(clk), .reset(reset), .half(half), .one(one), .out(out), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step(input bit h, input bit o);
    int paid;
    @(negedge clk);
    half = h;
    one  = o;
    @(posedge clk);
    paid = (m_disp ? 0 : m_credit) + int'(h) + 2 * int'(o);
    if (paid >= 5) begin
      m_disp   = 1'b1;
      m_chg    = paid - 5;
      m_credit = 0;
    end else begin
      m_disp   = 1'b0;
      m_chg    = 0;
      m_credit = paid;
    end
    #1;
    chk("out", 32'(out), 32'(m_disp));
    chk("cout", 32'(cout), 32'(m_chg));
  endtask

  // Assert reset between edges and check the outputs clear without a clock edge.
  task automatic async_reset(input int hold_cycles);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    m_credit = 0;
    m_disp   = 1'b0;
    m_chg    = 0;
    for (int i = 0; i < hold_cycles; i++) begin
      half = 1'($urandom);
      one  = 1'($urandom);
      @(posedge clk);
      #1;
      chk("rst_hold_out", 32'(out), 32'd0);
      chk("rst_hold_cout", 32'(cout), 32'd0);
    end
    @(negedge clk);
    half  = 1'b0;
    one   = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    half  = 1'b0;
    one   = 1'b0;
    #0.1;
    chk("init_out", 32'(out), 32'd0);
    chk("init_cout", 32'(cout), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0);

    // Five halves, then idle.
    for (int i = 0; i < 5; i++) step(1, 0);
    step(0, 0);
    step(0, 0);

    // one, one, half -> exact price; one, one, one -> 0.5 change.
    step(0, 1); step(0, 1); step(1, 0); step(0, 0);
    step(0, 1); step(0, 1); step(0, 1); step(0, 0);

    // Both coins every cycle alternates C3 / D1.
    for (int i = 0; i < 6; i++) step(1, 1);
    step(0, 0);

    // Four halves then both -> change 1.0.
    for (int i = 0; i < 4; i++) step(1, 0);
    step(1, 1);
    step(0, 0);

    // Reset mid-purchase from C3, then confirm credit restarted at zero.
    step(0, 1); step(1, 0);
    async_reset(2);
    step(1, 0); step(0, 0); step(0, 1); step(0, 1); step(0, 0);

    // Reset while a dispense is showing.
    step(0, 1); step(0, 1); step(0, 1);
    async_reset(1);
    step(0, 0);

    // Random coins with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) < 3) async_reset($urandom_range(2));
      else step(1'($urandom_range(99) < 45), 1'($urandom_range(99) < 40));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
